exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
Execute stage of the 5-stage LoongArch pipeline. It sits between the decode stage (DS) and the memory stage (MS).
- Latches the DS bus and computes the ALU result.
- Detects address-misaligned (ALE) exceptions.
- Issues load/store requests on the SRAM-like data port using a req/addr_ok handshake.
- Hands the MS bus to the memory stage. MS waits for data_ok.

Parameters:
DS_TO_ES_BUS_WD, 245, width of decode→execute bus
ES_TO_MS_BUS_WD, 171, width of execute→memory bus
ECODE_ALE, 6'h09, address-misaligned exception code

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
final_ex  in  1  exception or ertn flush from WB; kills ES content
ms_allowin  in  1  MS can accept
es_allowin  out  1  ES can accept
ds_to_es_valid  in  1  DS bus valid
ds_to_es_bus  in  245  alu_op[12], src1/src2/rkd[32 each], 8 mem ops, res_from_mem, gr_we, dest[5], pc, csr re/num/wvalue/wmask/we, rdcntid, ertn, esubcode, ecode[6], ex
es_to_ms_valid  out  1  MS bus valid
es_to_ms_bus  out  171  bus to MS (layout below)
data_sram_req  out  1  request
data_sram_wr  out  1  1 = store
data_sram_size  out  2  0 = byte, 1 = half, 2 = word
data_sram_wstrb  out  4  byte enables
data_sram_addr  out  32  address
data_sram_wdata  out  32  store data
data_sram_addr_ok  in  1  request accepted
ms_ex  in  1  MS or WS holds an exception/ertn; suppress memory issue
es_forward  out  41  bypass/hazard info: [40] csr_re&valid, [39] load&valid, [38:7] alu_result, [6:2] dest, [1] gr_we, [0] es_valid

Behaviour:
- Reset state: es_valid=0, FSM=IDLE; data_sram_req=0, es_to_ms_valid=0, es_allowin=1.

Pipeline valid and bus latch:
- es_valid clears on reset or final_ex.
- Otherwise, when es_allowin, es_valid <= ds_to_es_valid.
- The DS bus is latched on ds_to_es_valid && es_allowin.
- es_allowin = !es_valid || es_ready_go && ms_allowin.
- es_to_ms_valid = es_valid && es_ready_go.

Address and ALE:
- addr = alu_result.
- ALE when (ld_w|st_w) && addr[1:0]!=0, or (ld_h|ld_hu|st_h) && addr[0]!=0.
- An incoming ex keeps its own ecode/esubcode (earlier exception has priority).
- Otherwise ALE sets ex=1, ecode=ECODE_ALE, esubcode=0.
- With ex set, gr_we is forced to 0.

Memory issue:
- mem_issue = es_valid & mem_op & ~ex_any & ~ms_ex & ~final_ex.

FSM, states IDLE and DONE:
- In IDLE: data_sram_req = mem_issue.
- On req&addr_ok with !ms_allowin → DONE.
- DONE: req=0. Return to IDLE when ms_allowin. No second request is ever made.
- Once raised, req and addr/size/wr/wstrb/wdata stay stable until addr_ok.
- Exception: final_ex withdraws req in that cycle, and the next state is IDLE.
- es_ready_go = !mem_op || ex_any || (req&&addr_ok) || state==DONE.
- addr_ok together with final_ex: the transfer counts as accepted; es_to_ms_valid=1 that cycle so MS abandons the returning data.

Store formatting:
- st_b: wdata={4{rkd[7:0]}}, wstrb=4'b0001<<addr[1:0], size 0.
- st_h: wdata={2{rkd[15:0]}}, wstrb = addr[1] ? 1100 : 0011, size 1.
- st_w: wdata=rkd, wstrb=1111, size 2.
- Loads: wr=0, wstrb=0000, size per width.

es_to_ms_bus layout (MSB→LSB):
st_w[170], rdcntid[169], ertn[168], esubcode[167], ecode[166:161], ex[160], csr_re[159], csr_num[158:145], csr_wvalue[144:113], csr_wmask[112:81], csr_we[80], addr[1:0][79:78], ld_w, ld_b, ld_bu, ld_h, ld_hu, st_b, st_h [77:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32] (vaddr on ALE), pc[31:0].

Decomposition:
- Shared package/header: bus widths, ECODE_* constants, FSM state encodings, DS bus field offsets.
- Sub-module: existing alu (alu_op, src1, src2 → result).
- Optional sub-module es_store_fmt (combinational wdata/wstrb/size).

Test Plan:
- st_h, addr 0x1C000002, rkd 0x1234ABCD, addr_ok same cycle → req 1 cycle, wr=1, size=1, wstrb=1100, wdata=0xABCDABCD; es_to_ms_valid=1 that cycle.
- ld_w, addr 0x1C000006 → req never asserted; bus ex=1, ecode=0x09, alu_result=0x1C000006, gr_we=0; es_to_ms_valid=1 immediately.
- ld_b, addr_ok delayed 3 cycles → req high 3+1 cycles with addr/size constant; es_allowin=0 until accept.
- addr_ok while ms_allowin=0 → FSM DONE, req=0 next cycle, no re-request; handoff on the cycle ms_allowin rises.
- final_ex while req pending without addr_ok → req drops that cycle; es_valid=0 next cycle; no MS transfer.
- st_w in ES with ms_ex=1 for 4 cycles → req stays 0 throughout; final_ex then clears ES with no store issued.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, exception codes,
// FSM encoding and the field layouts of the DS->ES and ES->MS buses.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 245;
    localparam int ES_TO_MS_BUS_WD = 171;
    localparam int ES_FORWARD_WD   = 41;

    localparam logic [5:0] ECODE_ALE = 6'h09;

    // One-hot positions inside alu_op
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef enum logic [0:0] {
        ES_IDLE = 1'b0,
        ES_DONE = 1'b1
    } es_state_e;

    typedef struct packed {
        logic ld_w, ld_b, ld_bu, ld_h, ld_hu, st_b, st_h, st_w;
    } mem_ops_t;

    // DS->ES bus, MSB first
    typedef struct packed {
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd;
        mem_ops_t    mem;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        csr_we;
        logic        rdcntid;
        logic        ertn;
        logic        esubcode;
        logic [5:0]  ecode;
        logic        ex;
    } ds_bus_t;

    // ES->MS bus, MSB first
    typedef struct packed {
        logic        st_w;
        logic        rdcntid;
        logic        ertn;
        logic        esubcode;
        logic [5:0]  ecode;
        logic        ex;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        csr_we;
        logic [1:0]  addr_lo;
        logic        ld_w, ld_b, ld_bu, ld_h, ld_hu, st_b, st_h;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    // Address-misaligned check for the access width selected by the mem ops
    function automatic logic addr_misaligned(mem_ops_t m, logic [1:0] a);
        logic word_s;
        logic half_s;
        word_s = m.ld_w | m.st_w;
        half_s = m.ld_h | m.ld_hu | m.st_h;
        return (word_s & (a != 2'b00)) | (half_s & a[0]);
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// SRAM-like data port: request/address phase with req/addr_ok handshake.
interface exe_stage_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;

    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok);
endinterface

// File: rtl/exe_stage_alu.sv
// Integer ALU of the execute stage; alu_op is one-hot.
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);

    // Select the result of the single active operation
    always_comb begin
        result = 32'd0;
        if (alu_op[ALU_ADD]) begin
            result = src1 + src2;
        end else if (alu_op[ALU_SUB]) begin
            result = src1 - src2;
        end else if (alu_op[ALU_SLT]) begin
            result = {31'd0, $signed(src1) < $signed(src2)};
        end else if (alu_op[ALU_SLTU]) begin
            result = {31'd0, src1 < src2};
        end else if (alu_op[ALU_AND]) begin
            result = src1 & src2;
        end else if (alu_op[ALU_NOR]) begin
            result = ~(src1 | src2);
        end else if (alu_op[ALU_OR]) begin
            result = src1 | src2;
        end else if (alu_op[ALU_XOR]) begin
            result = src1 ^ src2;
        end else if (alu_op[ALU_SLL]) begin
            result = src1 << src2[4:0];
        end else if (alu_op[ALU_SRL]) begin
            result = src1 >> src2[4:0];
        end else if (alu_op[ALU_SRA]) begin
            result = 32'($signed(src1) >>> src2[4:0]);
        end else if (alu_op[ALU_LUI]) begin
            result = src2;
        end else begin
            result = 32'd0;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// LoongArch execute stage: latches the DS bus, runs the ALU, flags ALE and
// issues one load/store request per instruction on the data SRAM port.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       final_ex,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    exe_stage_if.master                data_sram,
    input  logic                       ms_ex,
    output logic [ES_FORWARD_WD-1:0]   es_forward
);

    logic        es_valid_r;
    ds_bus_t     ds_bus_r;
    es_state_e   state_r;
    es_state_e   state_s;
    logic [31:0] alu_result_s;
    logic        load_s;
    logic        store_s;
    logic        mem_op_s;
    logic        ale_s;
    logic        ex_any_s;
    logic        gr_we_s;
    logic        pend_s;
    logic        mem_issue_s;
    logic        accept_s;
    logic        req_s;
    logic        es_ready_go_s;
    logic        wr_s;
    logic [1:0]  size_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;
    es_bus_t     bus_s;

    exe_stage_alu u_alu (
        .alu_op (ds_bus_r.alu_op),
        .src1   (ds_bus_r.src1),
        .src2   (ds_bus_r.src2),
        .result (alu_result_s)
    );

    assign load_s   = ds_bus_r.mem.ld_w | ds_bus_r.mem.ld_b | ds_bus_r.mem.ld_bu
                    | ds_bus_r.mem.ld_h | ds_bus_r.mem.ld_hu;
    assign store_s  = ds_bus_r.mem.st_b | ds_bus_r.mem.st_h | ds_bus_r.mem.st_w;
    assign mem_op_s = load_s | store_s;
    assign ale_s    = addr_misaligned(ds_bus_r.mem, alu_result_s[1:0]);
    assign ex_any_s = ds_bus_r.ex | ale_s;
    assign gr_we_s  = ds_bus_r.gr_we & ~ex_any_s;

    // pend_s ignores final_ex so an addr_ok arriving with a flush still counts
    assign pend_s        = (state_r == ES_IDLE) & es_valid_r & mem_op_s & ~ex_any_s & ~ms_ex;
    assign mem_issue_s   = pend_s & ~final_ex;
    assign accept_s      = pend_s & data_sram.addr_ok;
    assign es_ready_go_s = ~mem_op_s | ex_any_s | accept_s | (state_r == ES_DONE);

    assign es_allowin     = ~es_valid_r | (es_ready_go_s & ms_allowin);
    assign es_to_ms_valid = es_valid_r & es_ready_go_s;

    // Pipeline valid: a flush wins, otherwise advance whenever ES can accept
    always_ff @(posedge clk) begin
        if (reset || final_ex) begin
            es_valid_r <= 1'b0;
        end else if (es_allowin) begin
            es_valid_r <= ds_to_es_valid;
        end
    end

    // Capture the DS bus when a new instruction enters
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_bus_r <= {DS_TO_ES_BUS_WD{1'b0}};
        end else if (ds_to_es_valid && es_allowin) begin
            ds_bus_r <= ds_to_es_bus;
        end
    end

    // Request FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ES_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request FSM: DONE parks an accepted request until MS can take it
    always_comb begin
        state_s = state_r;
        req_s   = 1'b0;
        case (state_r)
            ES_IDLE: begin
                req_s = mem_issue_s;
                if (mem_issue_s && data_sram.addr_ok && !ms_allowin) begin
                    state_s = ES_DONE;
                end else begin
                    state_s = ES_IDLE;
                end
            end
            ES_DONE: begin
                if (final_ex || ms_allowin) begin
                    state_s = ES_IDLE;
                end else begin
                    state_s = ES_DONE;
                end
            end
            default: begin
                state_s = ES_IDLE;
            end
        endcase
    end

    // Store lane formatting and access size
    always_comb begin
        wr_s    = store_s;
        size_s  = 2'd0;
        wstrb_s = 4'b0000;
        wdata_s = ds_bus_r.rkd;
        if (ds_bus_r.mem.st_b) begin
            size_s  = 2'd0;
            wstrb_s = 4'b0001 << alu_result_s[1:0];
            wdata_s = {4{ds_bus_r.rkd[7:0]}};
        end else if (ds_bus_r.mem.st_h) begin
            size_s  = 2'd1;
            wstrb_s = alu_result_s[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{ds_bus_r.rkd[15:0]}};
        end else if (ds_bus_r.mem.st_w || ds_bus_r.mem.ld_w) begin
            size_s  = 2'd2;
            wstrb_s = ds_bus_r.mem.st_w ? 4'b1111 : 4'b0000;
        end else if (ds_bus_r.mem.ld_h || ds_bus_r.mem.ld_hu) begin
            size_s  = 2'd1;
        end else begin
            size_s  = 2'd0;
        end
    end

    assign data_sram.req   = req_s;
    assign data_sram.wr    = wr_s;
    assign data_sram.size  = size_s;
    assign data_sram.wstrb = wstrb_s;
    assign data_sram.addr  = alu_result_s;
    assign data_sram.wdata = wdata_s;

    // ES->MS bus; an earlier exception keeps its own code over ALE
    always_comb begin
        bus_s.st_w         = ds_bus_r.mem.st_w;
        bus_s.rdcntid      = ds_bus_r.rdcntid;
        bus_s.ertn         = ds_bus_r.ertn;
        bus_s.esubcode     = ds_bus_r.ex ? ds_bus_r.esubcode : (ale_s ? 1'b0 : ds_bus_r.esubcode);
        bus_s.ecode        = ds_bus_r.ex ? ds_bus_r.ecode : (ale_s ? ECODE_ALE : ds_bus_r.ecode);
        bus_s.ex           = ex_any_s;
        bus_s.csr_re       = ds_bus_r.csr_re;
        bus_s.csr_num      = ds_bus_r.csr_num;
        bus_s.csr_wvalue   = ds_bus_r.csr_wvalue;
        bus_s.csr_wmask    = ds_bus_r.csr_wmask;
        bus_s.csr_we       = ds_bus_r.csr_we;
        bus_s.addr_lo      = alu_result_s[1:0];
        bus_s.ld_w         = ds_bus_r.mem.ld_w;
        bus_s.ld_b         = ds_bus_r.mem.ld_b;
        bus_s.ld_bu        = ds_bus_r.mem.ld_bu;
        bus_s.ld_h         = ds_bus_r.mem.ld_h;
        bus_s.ld_hu        = ds_bus_r.mem.ld_hu;
        bus_s.st_b         = ds_bus_r.mem.st_b;
        bus_s.st_h         = ds_bus_r.mem.st_h;
        bus_s.res_from_mem = ds_bus_r.res_from_mem;
        bus_s.gr_we        = gr_we_s;
        bus_s.dest         = ds_bus_r.dest;
        bus_s.alu_result   = alu_result_s;
        bus_s.pc           = ds_bus_r.pc;
    end

    assign es_to_ms_bus = bus_s;
    assign es_forward   = {ds_bus_r.csr_re & es_valid_r, load_s & es_valid_r, alu_result_s,
                           ds_bus_r.dest, gr_we_s, es_valid_r};

endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against a transaction-level
// model of ALU results, alignment, store lanes and handshake timing.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         final_ex = 1'b0;
    logic         ms_allowin = 1'b1;
    logic         ms_ex = 1'b0;
    logic         ds_to_es_valid = 1'b0;
    logic [244:0] ds_to_es_bus = '0;
    logic         es_allowin;
    logic         es_to_ms_valid;
    logic [170:0] es_to_ms_bus;
    logic [40:0]  es_forward;

    int checks = 0;
    int errors = 0;

    exe_stage_if sram ();

    exe_stage dut (
        .clk            (clk),
        .reset          (reset),
        .final_ex       (final_ex),
        .ms_allowin     (ms_allowin),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .data_sram      (sram.master),
        .ms_ex          (ms_ex),
        .es_forward     (es_forward)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [170:0] got, input logic [170:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return 32'($signed(a) >>> b[4:0]);
            default: return b;
        endcase
    endfunction

    // Access width in bytes, 0 for non-memory instructions
    function automatic int width_of(input ds_bus_t d);
        if (d.mem.ld_w || d.mem.st_w) return 4;
        if (d.mem.ld_h || d.mem.ld_hu || d.mem.st_h) return 2;
        if (d.mem.ld_b || d.mem.ld_bu || d.mem.st_b) return 1;
        return 0;
    endfunction

    function automatic bit is_store(input ds_bus_t d);
        return d.mem.st_b || d.mem.st_h || d.mem.st_w;
    endfunction

    function automatic es_bus_t ref_out(input ds_bus_t d, input int op);
        es_bus_t e;
        logic [31:0] r;
        int w;
        bit mis;
        r   = ref_alu(op, d.src1, d.src2);
        w   = width_of(d);
        mis = (w > 0) && ((r % 32'(w)) != 32'd0);
        e.st_w = d.mem.st_w;       e.rdcntid = d.rdcntid;     e.ertn = d.ertn;
        e.ex = d.ex || mis;
        e.ecode    = d.ex ? d.ecode : (mis ? 6'h09 : d.ecode);
        e.esubcode = d.ex ? d.esubcode : (mis ? 1'b0 : d.esubcode);
        e.csr_re = d.csr_re;       e.csr_num = d.csr_num;     e.csr_wvalue = d.csr_wvalue;
        e.csr_wmask = d.csr_wmask; e.csr_we = d.csr_we;       e.addr_lo = r[1:0];
        e.ld_w = d.mem.ld_w;  e.ld_b = d.mem.ld_b;  e.ld_bu = d.mem.ld_bu;
        e.ld_h = d.mem.ld_h;  e.ld_hu = d.mem.ld_hu; e.st_b = d.mem.st_b; e.st_h = d.mem.st_h;
        e.res_from_mem = d.res_from_mem;
        e.gr_we = d.gr_we && !e.ex;
        e.dest = d.dest;  e.alu_result = r;  e.pc = d.pc;
        return e;
    endfunction

    function automatic logic [40:0] ref_fwd(input ds_bus_t d, input es_bus_t e);
        bit ld;
        ld = d.mem.ld_w || d.mem.ld_b || d.mem.ld_bu || d.mem.ld_h || d.mem.ld_hu;
        return {d.csr_re, ld, e.alu_result, e.dest, e.gr_we, 1'b1};
    endfunction

    // Request-phase outputs: byte lanes derived from width and byte offset
    task automatic check_req(input string tag, input ds_bus_t d, input es_bus_t e);
        int w;
        int off;
        logic [3:0]  strb;
        logic [31:0] wd;
        w   = width_of(d);
        off = int'(e.alu_result[1:0]);
        strb = '0;
        wd   = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + w) strb[i] = 1'b1;
            wd[i*8 +: 8] = d.rkd[(i % w)*8 +: 8];
        end
        check_eq({tag, "_req"}, sram.req, 1'b1);
        check_eq({tag, "_addr"}, sram.addr, e.alu_result);
        check_eq({tag, "_wr"}, sram.wr, is_store(d));
        check_eq({tag, "_size"}, sram.size, (w == 4) ? 2'd2 : (w == 2) ? 2'd1 : 2'd0);
        check_eq({tag, "_wstrb"}, sram.wstrb, is_store(d) ? strb : 4'b0000);
        if (is_store(d)) check_eq({tag, "_wdata"}, sram.wdata, wd);
    endtask

    // Hand one instruction to ES and follow it until it leaves
    task automatic run_ins(input string tag, input ds_bus_t d, input int op, input int delay, input int hold);
        es_bus_t e;
        bit issue;
        e = ref_out(d, op);
        issue = (width_of(d) > 0) && !e.ex;
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = d;
        ms_allowin     = issue ? (hold == 0) : 1'b1;
        sram.addr_ok   = 1'b0;
        #1;
        check_eq({tag, "_idle_allowin"}, es_allowin, 1'b1);
        check_eq({tag, "_idle_msvalid"}, es_to_ms_valid, 1'b0);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        if (!issue) begin
            check_eq({tag, "_noreq"}, sram.req, 1'b0);
            check_eq({tag, "_msvalid"}, es_to_ms_valid, 1'b1);
            check_eq({tag, "_bus"}, es_to_ms_bus, e);
            check_eq({tag, "_fwd"}, es_forward, ref_fwd(d, e));
        end else begin
            for (int i = 0; i < delay; i++) begin
                check_req({tag, "_wait"}, d, e);
                check_eq({tag, "_wait_msvalid"}, es_to_ms_valid, 1'b0);
                check_eq({tag, "_wait_allowin"}, es_allowin, 1'b0);
                @(negedge clk);
                #1;
            end
            sram.addr_ok = 1'b1;
            #1;
            check_req({tag, "_acc"}, d, e);
            check_eq({tag, "_acc_msvalid"}, es_to_ms_valid, 1'b1);
            check_eq({tag, "_acc_bus"}, es_to_ms_bus, e);
            check_eq({tag, "_acc_fwd"}, es_forward, ref_fwd(d, e));
            check_eq({tag, "_acc_allowin"}, es_allowin, hold == 0);
            @(negedge clk);
            sram.addr_ok = 1'b0;
            for (int i = 0; i < hold; i++) begin
                #1;
                check_eq({tag, "_done_req"}, sram.req, 1'b0);
                check_eq({tag, "_done_msvalid"}, es_to_ms_valid, 1'b1);
                check_eq({tag, "_done_allowin"}, es_allowin, 1'b0);
                @(negedge clk);
            end
            if (hold > 0) begin
                ms_allowin = 1'b1;
                #1;
                check_eq({tag, "_hand_req"}, sram.req, 1'b0);
                check_eq({tag, "_hand_allowin"}, es_allowin, 1'b1);
                check_eq({tag, "_hand_bus"}, es_to_ms_bus, e);
            end
        end
    endtask

    task automatic mem_ins(output ds_bus_t d, input logic [31:0] addr, input logic [31:0] rkd, input logic [7:0] ops);
        d = '0;
        d.alu_op = 12'd1;
        d.src1 = addr;
        d.src2 = 32'd0;
        d.rkd = rkd;
        d.mem = ops;
        d.res_from_mem = (ops[7:3] != 5'd0);
        d.gr_we = (ops[7:3] != 5'd0);
        d.dest = 5'd7;
        d.pc = 32'h1C00_1000;
    endtask

    task automatic gen_ins(output ds_bus_t d, output int op);
        d = '0;
        d.rkd = $urandom;        d.dest = 5'($urandom);      d.pc = $urandom;
        d.gr_we = 1'($urandom);  d.csr_re = 1'($urandom);    d.csr_num = 14'($urandom);
        d.csr_wvalue = $urandom; d.csr_wmask = $urandom;     d.csr_we = 1'($urandom);
        d.rdcntid = 1'($urandom); d.ertn = 1'($urandom);     d.esubcode = 1'($urandom);
        d.ecode = 6'($urandom);  d.ex = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 9) < 4) begin
            op = $urandom_range(0, 11);
            d.src1 = $urandom;
            d.src2 = $urandom;
        end else begin
            op = 0;
            d.src1 = 32'h1C00_0000 + ($urandom & 32'h0000_FFF0);
            d.src2 = $urandom_range(0, 7);
            d.mem = 8'h80 >> $urandom_range(0, 7);
            d.res_from_mem = !is_store(d);
        end
        d.alu_op = 12'd1 << op;
    endtask

    initial begin
        ds_bus_t d;
        int op;
        sram.addr_ok = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_allowin", es_allowin, 1'b1);
        check_eq("rst_msvalid", es_to_ms_valid, 1'b0);
        check_eq("rst_req", sram.req, 1'b0);
        check_eq("rst_fwd_valid", es_forward[0], 1'b0);
        reset = 1'b0;

        mem_ins(d, 32'h1C00_0002, 32'h1234_ABCD, 8'h02);
        run_ins("st_h", d, 0, 0, 0);
        mem_ins(d, 32'h1C00_0006, 32'h0, 8'h80);
        run_ins("ld_w_ale", d, 0, 0, 0);
        mem_ins(d, 32'h1C00_0013, 32'h0, 8'h40);
        run_ins("ld_b_dly", d, 0, 3, 0);
        mem_ins(d, 32'h1C00_0020, 32'hCAFE_F00D, 8'h01);
        run_ins("st_w_hold", d, 0, 1, 3);

        // flush while the request waits for addr_ok
        mem_ins(d, 32'h1C00_0040, 32'h0, 8'h80);
        @(negedge clk);
        ds_to_es_valid = 1'b1; ds_to_es_bus = d;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        #1 check_eq("fx_req_before", sram.req, 1'b1);
        @(negedge clk);
        final_ex = 1'b1;
        #1;
        check_eq("fx_req_drop", sram.req, 1'b0);
        check_eq("fx_msvalid", es_to_ms_valid, 1'b0);
        @(negedge clk);
        final_ex = 1'b0;
        #1;
        check_eq("fx_valid_clr", es_forward[0], 1'b0);
        check_eq("fx_req_after", sram.req, 1'b0);

        // addr_ok coinciding with a flush still hands the access to MS
        @(negedge clk);
        ds_to_es_valid = 1'b1; ds_to_es_bus = d;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        final_ex = 1'b1; sram.addr_ok = 1'b1;
        #1;
        check_eq("fxok_req", sram.req, 1'b0);
        check_eq("fxok_msvalid", es_to_ms_valid, 1'b1);
        @(negedge clk);
        final_ex = 1'b0; sram.addr_ok = 1'b0;
        #1 check_eq("fxok_valid_clr", es_forward[0], 1'b0);

        // store held back by a downstream exception, then flushed
        mem_ins(d, 32'h1C00_0080, 32'h5555_AAAA, 8'h01);
        @(negedge clk);
        ds_to_es_valid = 1'b1; ds_to_es_bus = d; ms_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ds_to_es_valid = 1'b0;
            #1;
            check_eq("msex_req", sram.req, 1'b0);
            check_eq("msex_msvalid", es_to_ms_valid, 1'b0);
        end
        @(negedge clk);
        final_ex = 1'b1;
        #1 check_eq("msex_fx_req", sram.req, 1'b0);
        @(negedge clk);
        final_ex = 1'b0; ms_ex = 1'b0;
        #1;
        check_eq("msex_valid_clr", es_forward[0], 1'b0);
        check_eq("msex_req_after", sram.req, 1'b0);

        for (int n = 0; n < 200; n++) begin
            gen_ins(d, op);
            run_ins("rnd", d, op, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
